// File: rtl/gelu_requant.sv
// Requantizes the upstream integer GELU result (multiply, rounding shift, zero point, saturation)
// and buffers it in a first-word-fall-through FIFO; back-pressure is applied only via up_enable.
module gelu_requant #(
   parameter int D_W   = 32,
   parameter int M_W   = 16,
   parameter int O_W   = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [D_W-1:0]           qin,
   output logic                     up_enable,
   input  logic [M_W-1:0]           m,
   input  logic [5:0]               shift,
   input  logic [O_W-1:0]           zp,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [O_W-1:0]           qout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_ovf
);

   localparam int PW = D_W + M_W;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic signed [PW+1:0] SAT_MAX = {{(PW+3-O_W){1'b0}}, {(O_W-1){1'b1}}};
   localparam logic signed [PW+1:0] SAT_MIN = ~SAT_MAX;

   logic                 en_d;
   logic                 v0, v1, v2, v3;
   logic [D_W-1:0]       q0;
   logic signed [PW-1:0] p_q, p_next;
   logic signed [PW:0]   p_ext, rnd, rnd_sum, r_q, r_next;
   logic signed [PW+1:0] s_sum;
   logic [O_W-1:0]       s_q, s_next;

   logic [O_W-1:0]       mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        cnt;
   logic [CW:0]          occ;
   logic                 err;
   logic                 accept, push, pop, full, do_push;

   // Upstream data is only fresh after an edge where enable was high.
   assign accept = in_valid && en_d;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
      if (rst) begin
         en_d <= 1'b0;
         v0   <= 1'b0;
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
      end else begin
         en_d <= up_enable;
         v0   <= accept;
         v1   <= v0;
         v2   <= v1;
         v3   <= v2;
      end
   end

   // Data path registers free-run; the valid chain qualifies them.
   always_ff @(posedge clk) begin
      q0  <= qin;
      p_q <= p_next;
      r_q <= r_next;
      s_q <= s_next;
   end

   always_comb begin
      p_next = $signed({{M_W{q0[D_W-1]}}, q0}) * $signed({{D_W{m[M_W-1]}}, m});
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      p_ext   = {p_q[PW-1], p_q};
      rnd     = '0;
      rnd_sum = p_ext;
      r_next  = p_ext;
      if (shift != 6'd0) begin
         rnd     = (PW+1)'(1) << (shift - 6'd1);
         rnd_sum = p_ext + rnd;
         r_next  = rnd_sum >>> shift;
      end
   end

   always_comb begin
      s_sum = $signed({r_q[PW], r_q}) + $signed({{(PW+2-O_W){zp[O_W-1]}}, zp});
      if (s_sum > SAT_MAX)
         s_next = SAT_MAX[O_W-1:0];
      else if (s_sum < SAT_MIN)
         s_next = SAT_MIN[O_W-1:0];
      else
         s_next = s_sum[O_W-1:0];
   end

   assign push    = v3;
   assign pop     = out_valid && out_ready;
   assign full    = (cnt == CW'(DEPTH));
   assign do_push = push && !full;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         err    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + CW'(do_push) - CW'(pop);
         if (push && full) err <= 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= s_q;
   end

   // Two slots of slack cover the sample already presented and the one being enabled.
   assign occ       = (CW+1)'(cnt) + (CW+1)'(v0) + (CW+1)'(v1) + (CW+1)'(v2) + (CW+1)'(v3);
   assign up_enable = !rst && (occ <= (CW+1)'(DEPTH - 2));

   assign out_valid = (cnt != '0);
   assign qout      = out_valid ? mem[rd_ptr] : '0;
   assign count     = cnt;
   assign err_ovf   = err;

endmodule

// File: tb/tb_gelu_requant.sv
// Scoreboard bench for gelu_requant: an upstream model honours up_enable, expected values come
// from a plain-arithmetic reference, and a monitor pops and compares whenever the DUT pops.
module tb_gelu_requant;

   localparam int D_W   = 32;
   localparam int M_W   = 16;
   localparam int O_W   = 8;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic [D_W-1:0] qin = '0;
   logic           up_enable;
   logic [M_W-1:0] m = '0;
   logic [5:0]     shift = '0;
   logic [O_W-1:0] zp = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [O_W-1:0] qout;
   logic [CW-1:0]  count;
   logic           err_ovf;

   typedef struct {
      bit             valid;
      logic [D_W-1:0] q;
      bit             lat;
      bit             has_exp;
      logic [O_W-1:0] exp_val;
   } stim_t;

   typedef struct {
      logic [O_W-1:0] val;
      int             acc;
      bit             lat;
   } exp_t;

   stim_t stim_q[$];
   exp_t  exp_q[$];
   int    n_checks  = 0;
   int    n_errors  = 0;
   int    cyc       = 0;
   int    max_count = 0;
   bit    rand_ready = 1'b0;

   gelu_requant #(.D_W(D_W), .M_W(M_W), .O_W(O_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .qin       (qin),
      .up_enable (up_enable),
      .m         (m),
      .shift     (shift),
      .zp        (zp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .qout      (qout),
      .count     (count),
      .err_ovf   (err_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: real-number rounding of p / 2^shift (half toward +inf), then offset and clamp.
   function automatic logic [O_W-1:0] ref_model(logic [D_W-1:0] q);
      longint p, r, s, lo, hi;
      int     sh;
      p  = longint'($signed(q)) * longint'($signed(m));
      sh = int'(shift);
      if (sh == 0) r = p;
      else         r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
      s  = r + longint'($signed(zp));
      hi = (longint'(1) <<< (O_W - 1)) - 1;
      lo = -hi - 1;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      return s[O_W-1:0];
   endfunction

   task automatic add(bit v, int q, bit lat = 1'b0, bit has_exp = 1'b0, int exp_val = 0);
      stim_t s;
      s.valid   = v;
      s.q       = q;
      s.lat     = lat;
      s.has_exp = has_exp;
      s.exp_val = exp_val[O_W-1:0];
      stim_q.push_back(s);
   endtask

   task automatic set_cfg(int mm, int sh, int z);
      m     = mm[M_W-1:0];
      shift = sh[5:0];
      zp    = z[O_W-1:0];
   endtask

   task automatic set_ready(bit v);
      @(posedge clk);
      #1 out_ready = v;
   endtask

   task automatic wait_drain();
      rand_ready = 1'b0;
      set_ready(1'b1);
      for (int i = 0; i < 3000; i++) begin
         if (stim_q.size() == 0 && exp_q.size() == 0) break;
         @(posedge clk);
      end
      check("drain_outstanding", exp_q.size() + stim_q.size(), 0);
      repeat (10) @(posedge clk);
   endtask

   // Upstream model: produces its next sample only after an edge where up_enable was high.
   initial begin : upstream
      bit    en;
      stim_t s;
      exp_t  e;
      forever begin
         @(negedge clk);
         en = up_enable;
         @(posedge clk);
         #1;
         if (en) begin
            if (stim_q.size() > 0) begin
               s        = stim_q.pop_front();
               in_valid = s.valid;
               qin      = s.q;
               if (s.valid) begin
                  e.val = s.has_exp ? s.exp_val : ref_model(s.q);
                  e.acc = cyc + 1;
                  e.lat = s.lat;
                  exp_q.push_back(e);
               end
            end else begin
               in_valid = 1'b0;
            end
         end
      end
   end

   initial begin : ready_gen
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && int'(count) > max_count) max_count = int'(count);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_output: got qout=%0d, expected no output (cycle %0d)",
                        $signed(qout), cyc);
            end else begin
               e = exp_q.pop_front();
               check("qout", $signed(qout), $signed(e.val));
               if (e.lat) check("latency_edges", cyc - e.acc, 4);
            end
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 60000", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_up_enable", up_enable, 0);
      check("rst_err_ovf", err_ovf, 0);
      check("rst_qout", qout, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("up_enable_after_rst", up_enable, 1);

      // Latency and exact value: 100 * 16384 / 2^15 = 50
      set_ready(1'b1);
      set_cfg(16384, 15, 0);
      add(1'b1, 100, 1'b1, 1'b1, 50);
      wait_drain();

      set_cfg(1, 1, 5);
      add(1'b1, -3, 1'b0, 1'b1, 4);
      wait_drain();
      set_cfg(1, 0, 0);
      add(1'b1, -1000, 1'b0, 1'b1, -128);
      add(1'b1, 1000, 1'b0, 1'b1, 127);
      add(1'b1, -7, 1'b0, 1'b1, -7);
      wait_drain();

      // Random configurations, bubbles and downstream stalls
      for (int c = 0; c < 5; c++) begin
         if (c == 0) set_cfg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 47)), int'($urandom_range(0, 255)));
         else        set_cfg(int'($urandom_range(0, 65535)), int'($urandom_range(14, 40)), int'($urandom_range(0, 255)));
         rand_ready = 1'b1;
         for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) add($urandom_range(0, 3) != 0, int'($urandom()));
            else add($urandom_range(0, 3) != 0, int'($urandom_range(0, 4000)) - 2000);
         end
         wait_drain();
      end

      // Full back-pressure: FIFO fills exactly to DEPTH, enable held low, no overflow
      set_cfg(3, 2, -4);
      max_count = 0;
      set_ready(1'b0);
      for (int i = 0; i < 2 * DEPTH; i++) add(1'b1, i * 37 - 200);
      repeat (40) @(negedge clk);
      check("bp_count_full", count, DEPTH);
      check("bp_up_enable_low", up_enable, 0);
      check("bp_err_ovf", err_ovf, 0);
      check("bp_max_count", max_count, DEPTH);
      wait_drain();

      // Release at count=DEPTH-1 with a push in flight, then stream enough to wrap the pointers
      set_cfg(-5, 1, 10);
      set_ready(1'b0);
      for (int i = 0; i < 3 * DEPTH; i++) add(1'b1, i * 11 - 90);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (count == CW'(DEPTH - 1)) break;
      end
      check("wrap_reach_depth_m1", count, DEPTH - 1);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("wrap_push_pop_count_stable", count, DEPTH - 1);
      wait_drain();
      check("wrap_err_ovf", err_ovf, 0);
      check("wrap_count_empty", count, 0);

      // Reset with five samples in flight / buffered
      set_cfg(2, 0, 1);
      set_ready(1'b0);
      for (int i = 0; i < 5; i++) add(1'b1, i + 20);
      repeat (8) @(negedge clk);
      check("pre_rst_busy", count != 0, 1);
      @(posedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      stim_q.delete();
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_count", count, 0);
      check("midrst_up_enable", up_enable, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("midrst_up_enable_release", up_enable, 1);

      // Traffic after reset must show none of the discarded samples
      set_ready(1'b1);
      for (int i = 0; i < 6; i++) add(1'b1, i * 3 - 8);
      wait_drain();
      check("final_err_ovf", err_ovf, 0);
      check("final_count", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
